// File: rtl/universal_shift_register.sv
// universal_shift_register: hold / shift right / shift left / parallel load register, zero-fill shifts
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d, q_q;
    // next-state select; an unknown mode code falls to the default and holds
    always_comb begin
        q_d = q_q;
        case (mode)
            2'b01:   q_d = {1'b0, q_q[WIDTH-1:1]};
            2'b10:   q_d = {q_q[WIDTH-2:0], 1'b0};
            2'b11:   q_d = parallel_in;
            default: q_d = q_q;
        endcase
    end
    // register bank, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed checks of the 4-bit and 8-bit configurations
module tb_universal_shift_register;
    logic       clk = 1'b0;
    logic       reset4, reset8;
    logic [1:0] mode4, mode8;
    logic [3:0] pin4, q4;
    logic [7:0] pin8, q8;
    int errs = 0;
    int checks = 0;

    universal_shift_register #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .mode(mode4), .parallel_in(pin4), .q(q4)
    );
    universal_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .mode(mode8), .parallel_in(pin8), .q(q8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic [1:0] m, input logic [3:0] p, input string tag, input logic [3:0] exp);
        mode4 = m;
        pin4  = p;
        step();
        chk(tag, {4'b0, q4}, {4'b0, exp});
    endtask

    task automatic op8(input logic [1:0] m, input logic [7:0] p, input string tag, input logic [7:0] exp);
        mode8 = m;
        pin8  = p;
        step();
        chk(tag, q8, exp);
    endtask

    initial begin
        reset4 = 1'b1; reset8 = 1'b1;
        mode4 = 2'b00; mode8 = 2'b00;
        pin4 = '0; pin8 = '0;
        step();
        chk("reset4_init", {4'b0, q4}, 8'h00);
        chk("reset8_init", q8, 8'h00);
        reset4 = 1'b0;
        reset8 = 1'b0;
        // first edge after release performs the load
        op4(2'b11, 4'b1111, "load_1111", 4'b1111);
        #3 reset4 = 1'b1;
        #1 chk("async_reset_mid", {4'b0, q4}, 8'h00);
        mode4 = 2'b11; pin4 = 4'b1111;
        step();
        chk("reset_held_1", {4'b0, q4}, 8'h00);
        step();
        chk("reset_held_2", {4'b0, q4}, 8'h00);
        reset4 = 1'b0;
        // load and hold
        op4(2'b11, 4'b1010, "load_1010", 4'b1010);
        for (int i = 0; i < 3; i++) op4(2'b00, 4'b0110, "hold", 4'b1010);
        // shift right run into zero
        op4(2'b01, 4'b1111, "shr1", 4'b0101);
        op4(2'b01, 4'b1111, "shr2", 4'b0010);
        op4(2'b01, 4'b1111, "shr3", 4'b0001);
        op4(2'b01, 4'b1111, "shr4", 4'b0000);
        op4(2'b01, 4'b1111, "shr5", 4'b0000);
        // shift left run into zero
        op4(2'b11, 4'b1101, "load_1101", 4'b1101);
        op4(2'b10, 4'b1111, "shl1", 4'b1010);
        op4(2'b10, 4'b1111, "shl2", 4'b0100);
        op4(2'b10, 4'b1111, "shl3", 4'b1000);
        op4(2'b10, 4'b1111, "shl4", 4'b0000);
        // per-cycle mode changes
        op4(2'b11, 4'b1001, "load_1001", 4'b1001);
        op4(2'b01, 4'b1111, "mix_shr", 4'b0100);
        op4(2'b10, 4'b1111, "mix_shl1", 4'b1000);
        op4(2'b10, 4'b1111, "mix_shl2", 4'b0000);
        op4(2'b11, 4'b0111, "mix_load", 4'b0111);
        op4(2'b00, 4'b0000, "mix_hold", 4'b0111);
        // unknown mode holds
        op4(2'bxx, 4'b0000, "mode_x_hold", 4'b0111);
        // input changes between edges have no effect
        mode4 = 2'b11; pin4 = 4'b0001;
        #3 mode4 = 2'b00;
        step();
        chk("between_edges", {4'b0, q4}, 8'h07);
        // 8-bit configuration
        op8(2'b11, 8'b10000001, "w8_load", 8'b10000001);
        op8(2'b01, 8'b11111111, "w8_shr", 8'b01000000);
        op8(2'b10, 8'b11111111, "w8_shl1", 8'b10000000);
        op8(2'b10, 8'b11111111, "w8_shl2", 8'b00000000);
        op8(2'b11, 8'b11110000, "w8_load2", 8'b11110000);
        op8(2'b01, 8'b00000000, "w8_shr2", 8'b01111000);
        #3 reset8 = 1'b1;
        #1 chk("w8_async_reset", q8, 8'h00);
        #2 reset8 = 1'b0;
        op8(2'b01, 8'b00000000, "w8_resume", 8'b00000000);
        op8(2'b11, 8'b00111100, "w8_load3", 8'b00111100);
        op8(2'b10, 8'b00000000, "w8_shl3", 8'b01111000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
